dual_ram_fifo_ctrl: RTL and testbench
=====================================

Name: dual_ram_fifo_ctrl

Overview:
Initiator-side controller that drives a dual_ram-style simple dual-port RAM (registered read, one write port and one read port) as a synchronous FIFO. It converts push/pop requests into RAM write/read strobes and addresses, and tracks occupancy. It passes write data through to the RAM and returns RAM read data with a valid flag. It sits between a producer/consumer pair and one RAM instance on the same clock.

Parameters:
RAM_WIDTH, 8, data word width; must match the attached RAM.
ADDR_SIZE, 4, RAM address width; FIFO depth is 2**ADDR_SIZE.
AFULL_LEVEL, 12, almost_full asserts when count >= AFULL_LEVEL; legal range is 1..2**ADDR_SIZE.

Ports:
clk  in  1  rising-edge clock shared with the RAM
reset  in  1  asynchronous, active-high reset
push  in  1  producer write request
push_data  in  RAM_WIDTH  producer write data
pop  in  1  consumer read request
pop_data  out  RAM_WIDTH  read data, valid when pop_valid=1
pop_valid  out  1  asserted one cycle after an accepted pop
full  out  1  FIFO holds 2**ADDR_SIZE words
empty  out  1  FIFO holds 0 words
almost_full  out  1  count >= AFULL_LEVEL
count  out  ADDR_SIZE+1  current occupancy
overflow  out  1  sticky: push seen while full
underflow  out  1  sticky: pop seen while empty
err_clr  in  1  synchronous clear of overflow/underflow
ram_write  out  1  to RAM write
ram_wr_addr  out  ADDR_SIZE  to RAM wr_addr
ram_data_in  out  RAM_WIDTH  to RAM data_in
ram_read  out  1  to RAM read
ram_rd_addr  out  ADDR_SIZE  to RAM rd_addr
ram_data_out  in  RAM_WIDTH  from RAM data_out

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock. On reset: wr_ptr=0, rd_ptr=0, count=0, pop_valid=0, overflow=0, underflow=0. The outputs then settle to empty=1, full=0, almost_full=0. RAM contents are don't-care after reset; the controller never reads an unwritten slot.
- Pointers: wr_ptr and rd_ptr are each ADDR_SIZE+1 bits. The RAM addresses are the low ADDR_SIZE bits; the MSB is the wrap bit.
- Flags: empty when the pointers are equal. full when the low bits are equal and the MSBs differ. count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_SIZE+1). All flags and count derive combinationally from the registered pointers.
- Accept rules:
  - push_ok = push & ~full.
  - pop_ok = pop & ~empty.
  - ram_write = push_ok and ram_read = pop_ok, both combinational in the same cycle.
  - ram_wr_addr = wr_ptr[ADDR_SIZE-1:0] and ram_rd_addr = rd_ptr[ADDR_SIZE-1:0].
  - ram_data_in = push_data.
- Updates on each clk edge: wr_ptr += push_ok and rd_ptr += pop_ok. Pointers wrap naturally at 2**(ADDR_SIZE+1).
- Read latency: the RAM registers data_out on the edge at which ram_read=1. pop_valid is registered (pop_valid <= pop_ok), so pop_data = ram_data_out is valid in the cycle after the accepted pop. Back-to-back pops give one word per cycle.
- Simultaneous push and pop:
  - Not empty and not full: both are accepted and count is unchanged.
  - Full: pop accepted, push rejected, overflow set.
  - Empty: push accepted, pop rejected, underflow set. There is no fall-through, so the word is readable from the next cycle.
- Same-address hazard: a read and a write never target the same slot in one cycle. When empty, the read is blocked; when full, the write is blocked.
- Error flags: overflow <= (overflow | (push & full)) & ~err_clr, and likewise underflow with pop & empty. If err_clr and a new error occur in the same cycle, err_clr wins.
- Reset mid-operation: an in-flight pop_valid is dropped immediately and the FIFO reads empty on the next cycle.

Decomposition:
- Shared package holds: localparam DEPTH = 2**ADDR_SIZE, the pointer width ADDR_SIZE+1, and the full/empty compare helper functions.
- One natural sub-module, fifo_ptr: an (ADDR_SIZE+1)-bit wrapping pointer with an increment enable and async reset. It is instantiated twice, for write and read.
- The RAM is external and not instantiated here. A top-level wrapper pairs it with dual_ram.

Test Plan (ADDR_SIZE=4, RAM_WIDTH=8, AFULL_LEVEL=12, with dual_ram attached):
1. Reset, then 16 pushes of 0x00..0x0F. Expect: count 1..16; almost_full rises after the 12th push's edge; full after the 16th. Then a 17th push of 0xAA: ram_write=0, overflow=1, count stays 16.
2. From full, 16 consecutive pops. Expect: pop_valid=1 for cycles 1..16 after the first pop, pop_data 0x00..0x0F in order; empty after the last pop. A further pop gives ram_read=0 and underflow=1.
3. Wrap: push 10 and pop 10, repeated 3 times (pointers cross 16 and 32). Expect data in order every pass and ram_wr_addr to cycle through 0..15 correctly.
4. With count=5, push 0x55 and pop in the same cycle for 8 cycles. Expect count to hold at 5 and the popped data to follow the earlier pushes in FIFO order.
5. When empty, push 0x77 and pop simultaneously. Expect: pop rejected, underflow=1, count=1. Then pop: pop_data=0x77 one cycle later.
6. With count=7 and pop_valid pending, assert reset asynchronously mid-cycle. Expect count=0, empty=1 and pop_valid=0 before the next edge. Then err_clr=1 clears the sticky flags.

Source files
------------

// File: rtl/dual_ram_fifo_ctrl_pkg.sv
// rtl/dual_ram_fifo_ctrl_pkg.sv - shared sizing and pointer-compare helpers for the RAM FIFO controller
package dual_ram_fifo_ctrl_pkg;

    localparam int DEF_ADDR_SIZE = 4;
    localparam int DEF_DEPTH     = 2 ** DEF_ADDR_SIZE;
    localparam int DEF_PTR_W     = DEF_ADDR_SIZE + 1;

    // Both helpers take wr_ptr ^ rd_ptr, zero-extended to 32 bits.
    function automatic logic ptrs_empty(input logic [31:0] ptr_xor);
        return ptr_xor == 32'd0;
    endfunction

    // Full means only the wrap bit differs.
    function automatic logic ptrs_full(input logic [31:0] ptr_xor, input int addr_size);
        return ptr_xor == (32'd1 << addr_size);
    endfunction

endpackage

// File: rtl/dual_ram_fifo_ctrl_ptr.sv
// rtl/dual_ram_fifo_ctrl_ptr.sv - wrapping FIFO pointer with increment enable
module fifo_ptr
    import dual_ram_fifo_ctrl_pkg::*;
#(
    parameter int W = DEF_PTR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] ptr
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + W'(1);
        end
    end

endmodule

// File: rtl/dual_ram_fifo_ctrl.sv
// rtl/dual_ram_fifo_ctrl.sv - drives a registered-read simple dual-port RAM as a synchronous FIFO
module dual_ram_fifo_ctrl
    import dual_ram_fifo_ctrl_pkg::*;
#(
    parameter int RAM_WIDTH   = 8,
    parameter int ADDR_SIZE   = DEF_ADDR_SIZE,
    parameter int AFULL_LEVEL = DEF_DEPTH - 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 push,
    input  logic [RAM_WIDTH-1:0] push_data,
    input  logic                 pop,
    output logic [RAM_WIDTH-1:0] pop_data,
    output logic                 pop_valid,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic [ADDR_SIZE:0]   count,
    output logic                 overflow,
    output logic                 underflow,
    input  logic                 err_clr,
    output logic                 ram_write,
    output logic [ADDR_SIZE-1:0] ram_wr_addr,
    output logic [RAM_WIDTH-1:0] ram_data_in,
    output logic                 ram_read,
    output logic [ADDR_SIZE-1:0] ram_rd_addr,
    input  logic [RAM_WIDTH-1:0] ram_data_out
);

    localparam int PTR_W = ADDR_SIZE + 1;

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    fifo_ptr #(.W(PTR_W)) u_wr_ptr (.clk(clk), .reset(reset), .inc(push_ok), .ptr(wr_ptr));
    fifo_ptr #(.W(PTR_W)) u_rd_ptr (.clk(clk), .reset(reset), .inc(pop_ok),  .ptr(rd_ptr));

    assign empty       = ptrs_empty(32'(wr_ptr ^ rd_ptr));
    assign full        = ptrs_full(32'(wr_ptr ^ rd_ptr), ADDR_SIZE);
    assign count       = wr_ptr - rd_ptr;
    assign almost_full = count >= PTR_W'(AFULL_LEVEL);

    // Blocking on full/empty also guarantees read and write never hit the same slot.
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    assign ram_write   = push_ok;
    assign ram_wr_addr = wr_ptr[ADDR_SIZE-1:0];
    assign ram_data_in = push_data;
    assign ram_read    = pop_ok;
    assign ram_rd_addr = rd_ptr[ADDR_SIZE-1:0];
    assign pop_data    = ram_data_out;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= pop_ok;
            overflow  <= (overflow | (push & full)) & ~err_clr;
            underflow <= (underflow | (pop & empty)) & ~err_clr;
        end
    end

endmodule

// File: tb/tb_dual_ram_fifo_ctrl.sv
// tb/tb_dual_ram_fifo_ctrl.sv - directed self-checking bench for dual_ram_fifo_ctrl with a behavioural dual_ram
module tb_dual_ram_fifo_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic [7:0] push_data = 8'h00;
    logic       pop = 1'b0;
    logic [7:0] pop_data;
    logic       pop_valid;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;
    logic       err_clr = 1'b0;
    logic       ram_write;
    logic [3:0] ram_wr_addr;
    logic [7:0] ram_data_in;
    logic       ram_read;
    logic [3:0] ram_rd_addr;
    logic [7:0] ram_data_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mem [16];

    always #5 clk = ~clk;

    // Attached RAM: one write port, one read port, data_out registered on read.
    always @(posedge clk) begin
        if (ram_write) mem[ram_wr_addr] <= ram_data_in;
        if (ram_read)  ram_data_out <= mem[ram_rd_addr];
    end

    dual_ram_fifo_ctrl #(.RAM_WIDTH(8), .ADDR_SIZE(4), .AFULL_LEVEL(12)) dut (
        .clk(clk), .reset(reset), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .err_clr(err_clr), .ram_write(ram_write),
        .ram_wr_addr(ram_wr_addr), .ram_data_in(ram_data_in), .ram_read(ram_read),
        .ram_rd_addr(ram_rd_addr), .ram_data_out(ram_data_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] waddr;
        logic [7:0] d;

        // 1: reset state, fill to full, overflow
        cyc(); cyc();
        reset = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_pvalid", pop_valid, 0);
        check("rst_ovf", overflow, 0);
        check("rst_unf", underflow, 0);
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; push_data = 8'(i);
            #1;
            check("fill_wr", ram_write, 1);
            check("fill_waddr", ram_wr_addr, i);
            cyc();
            check("fill_count", count, i + 1);
            check("fill_afull", almost_full, (i + 1) >= 12);
            check("fill_full", full, (i + 1) == 16);
        end
        push_data = 8'hAA;
        #1;
        check("ovf_wr_blocked", ram_write, 0);
        cyc();
        push = 1'b0;
        check("ovf_flag", overflow, 1);
        check("ovf_count", count, 16);

        // 2: drain in order, then underflow
        for (int i = 0; i < 16; i++) begin
            pop = 1'b1;
            #1;
            check("drain_rd", ram_read, 1);
            check("drain_raddr", ram_rd_addr, i);
            cyc();
            check("drain_pvalid", pop_valid, 1);
            check("drain_data", pop_data, i);
        end
        check("drain_empty", empty, 1);
        check("drain_ovf_sticky", overflow, 1);
        #1;
        check("unf_rd_blocked", ram_read, 0);
        cyc();
        pop = 1'b0;
        check("unf_flag", underflow, 1);
        check("unf_pvalid", pop_valid, 0);
        err_clr = 1'b1;
        cyc();
        err_clr = 1'b0;
        check("clr_ovf", overflow, 0);
        check("clr_unf", underflow, 0);

        // 3: wrap passes; pointers sit at 16 here, so addresses start at 0
        waddr = 4'd0;
        for (int p = 0; p < 3; p++) begin
            for (int j = 0; j < 10; j++) begin
                d = 8'(8'h30 + p * 16 + j);
                push = 1'b1; push_data = d;
                #1;
                check("wrap_waddr", ram_wr_addr, waddr);
                exp_q.push_back(d);
                waddr = waddr + 4'd1;
                cyc();
            end
            push = 1'b0;
            check("wrap_count", count, 10);
            for (int j = 0; j < 10; j++) begin
                pop = 1'b1;
                cyc();
                check("wrap_data", pop_data, exp_q.pop_front());
            end
            pop = 1'b0;
            check("wrap_empty", empty, 1);
        end

        // 4: steady state push+pop at count 5
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 8'(8'hA0 + i);
            exp_q.push_back(push_data);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            push = 1'b1; pop = 1'b1; push_data = 8'(8'h50 + k);
            exp_q.push_back(push_data);
            cyc();
            check("both_count", count, 5);
            check("both_data", pop_data, exp_q.pop_front());
        end
        push = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pop = 1'b1;
            cyc();
            check("both_drain", pop_data, exp_q.pop_front());
        end
        pop = 1'b0;
        check("both_empty", empty, 1);

        // 5: push+pop while empty: no fall-through
        push = 1'b1; pop = 1'b1; push_data = 8'h77;
        #1;
        check("emp_rd_blocked", ram_read, 0);
        check("emp_wr", ram_write, 1);
        cyc();
        push = 1'b0;
        check("emp_unf", underflow, 1);
        check("emp_count", count, 1);
        check("emp_pvalid", pop_valid, 0);
        cyc();
        pop = 1'b0;
        check("emp_pop_valid", pop_valid, 1);
        check("emp_pop_data", pop_data, 8'h77);
        check("emp_empty", empty, 1);

        // 6: async reset with a pop in flight, then err_clr beats a new error
        for (int i = 0; i < 8; i++) begin
            push = 1'b1; push_data = 8'(i);
            cyc();
        end
        push = 1'b0; pop = 1'b1;
        cyc();
        pop = 1'b0;
        check("pre_rst_count", count, 7);
        check("pre_rst_pvalid", pop_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_pvalid", pop_valid, 0);
        check("arst_unf", underflow, 0);
        #1 reset = 1'b0;
        cyc();
        pop = 1'b1;
        cyc();
        pop = 1'b0;
        check("post_rst_unf", underflow, 1);
        pop = 1'b1; err_clr = 1'b1;
        cyc();
        pop = 1'b0; err_clr = 1'b0;
        check("clr_wins", underflow, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
